// File: rtl/lvds_link_ctrl.sv
// LVDS receiver word-alignment controller: waits for a settled link, hunts for
// comma words with deserializer bitslips, then watches the locked link for loss.
module lvds_link_ctrl #(
    parameter logic [9:0] COMMA1     = 10'b01_0111_1100,
    parameter logic [9:0] COMMA2     = 10'b10_1000_0011,
    parameter int         SLIP_GAP   = 8,
    parameter int         CHECK_LEN  = 4,
    parameter int         MAX_SLIPS  = 10,
    parameter int         LOSS_LIMIT = 16
) (
    input  logic       rx_clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic [9:0] rx_data,
    input  logic       retrain,
    output logic       bitslip,
    output logic       align_done,
    output logic       train_fail,
    output logic [3:0] slip_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_CHECK  = 3'd2,
        S_SLIP   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    // Terminal counts: each counter starts at 0 on entry, so the last cycle is N-1.
    localparam logic [7:0] WAIT_LAST = 8'(SLIP_GAP - 1);
    localparam logic [3:0] HIT_LAST  = 4'(CHECK_LEN - 1);
    localparam logic [7:0] GAP_LAST  = 8'(LOSS_LIMIT - 1);
    localparam logic [3:0] SLIP_MAX  = 4'(MAX_SLIPS);

    state_t     r_state;
    logic       r_bitslip;
    logic       r_align_done;
    logic       r_train_fail;
    logic [3:0] r_slip_cnt;
    logic [3:0] r_hit_cnt;
    logic [7:0] r_wait_cnt;
    logic [7:0] r_gap_cnt;
    logic       w_comma;

    assign w_comma = (rx_data == COMMA1) || (rx_data == COMMA2);

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bitslip    <= 1'b0;
            r_align_done <= 1'b0;
            r_train_fail <= 1'b0;
            r_slip_cnt   <= 4'd0;
            r_hit_cnt    <= 4'd0;
            r_wait_cnt   <= 8'd0;
            r_gap_cnt    <= 8'd0;
        end else begin
            r_bitslip <= 1'b0;
            // PLL loss outranks retrain, though both land in IDLE with counters cleared.
            if ((!pll_locked && (r_state != S_IDLE)) || retrain) begin
                r_state      <= S_IDLE;
                r_align_done <= 1'b0;
                r_train_fail <= 1'b0;
                r_slip_cnt   <= 4'd0;
                r_hit_cnt    <= 4'd0;
                r_wait_cnt   <= 8'd0;
                r_gap_cnt    <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_slip_cnt <= 4'd0;
                        if (pll_locked) begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= 8'd0;
                        end
                    end
                    S_WAIT: begin
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_state   <= S_CHECK;
                            r_hit_cnt <= 4'd0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                    S_CHECK: begin
                        if (w_comma) begin
                            if (r_hit_cnt == HIT_LAST) begin
                                r_state      <= S_LOCKED;
                                r_gap_cnt    <= 8'd0;
                                r_align_done <= 1'b1;
                            end else begin
                                r_hit_cnt <= r_hit_cnt + 4'd1;
                            end
                        end else if (r_slip_cnt < SLIP_MAX) begin
                            r_state   <= S_SLIP;
                            r_bitslip <= 1'b1;
                        end else begin
                            r_state      <= S_FAIL;
                            r_train_fail <= 1'b1;
                        end
                    end
                    S_SLIP: begin
                        // Only reachable below SLIP_MAX, so this never wraps.
                        r_slip_cnt <= r_slip_cnt + 4'd1;
                        r_state    <= S_WAIT;
                        r_wait_cnt <= 8'd0;
                    end
                    S_LOCKED: begin
                        if (w_comma) begin
                            r_gap_cnt <= 8'd0;
                        end else if (r_gap_cnt == GAP_LAST) begin
                            r_state      <= S_WAIT;
                            r_wait_cnt   <= 8'd0;
                            r_slip_cnt   <= 4'd0;
                            r_align_done <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 8'd1;
                        end
                    end
                    S_FAIL: begin
                        r_train_fail <= 1'b1;
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_align_done <= 1'b0;
                        r_train_fail <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bitslip    = r_bitslip;
    assign align_done = r_align_done;
    assign train_fail = r_train_fail;
    assign slip_count = r_slip_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Bench for lvds_link_ctrl: cycle-by-cycle expected outputs derived from the
// documented timing, queued when stimulus is applied and checked after each edge.
module tb_lvds_link_ctrl;

    localparam logic [9:0] C1   = 10'b01_0111_1100;
    localparam logic [9:0] C2   = 10'b10_1000_0011;
    localparam logic [9:0] NC   = 10'h155;
    localparam logic [9:0] ZERO = 10'h000;
    localparam int         GAP  = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_SLIP   = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    logic       rx_clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic [9:0] rx_data = 10'h000;
    logic       retrain = 1'b0;
    logic       bitslip;
    logic       align_done;
    logic       train_fail;
    logic [3:0] slip_count;
    logic [2:0] state;

    lvds_link_ctrl dut (
        .rx_clk     (rx_clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .rx_data    (rx_data),
        .retrain    (retrain),
        .bitslip    (bitslip),
        .align_done (align_done),
        .train_fail (train_fail),
        .slip_count (slip_count),
        .state      (state)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       bs;
        logic       ad;
        logic       tf;
        logic [3:0] sc;
    } exp_t;

    typedef struct {
        string      name;
        logic       rs;
        logic       pl;
        logic       rt;
        logic [9:0] d;
        logic [2:0] st;
        logic       bs;
        logic       ad;
        logic       tf;
        logic [3:0] sc;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;
    int   last_bs = -1;
    int   bs_pulses = 0;
    bit   spacing_on = 1'b0;

    function automatic void add(input string n, input logic rs, input logic pl, input logic rt,
                                input logic [9:0] d, input logic [2:0] st, input logic bs,
                                input logic ad, input logic tf, input logic [3:0] sc);
        vec_t v;
        v.name = n; v.rs = rs; v.pl = pl; v.rt = rt; v.d = d;
        v.st = st; v.bs = bs; v.ad = ad; v.tf = tf; v.sc = sc;
        tbl.push_back(v);
    endfunction

    task automatic check_out();
        exp_t e;
        n_cmp++;
        cyc_no++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got no queued expectation, required one");
        end else begin
            e = sb_q.pop_front();
            if (state !== e.st || bitslip !== e.bs || align_done !== e.ad ||
                train_fail !== e.tf || slip_count !== e.sc) begin
                n_bad++;
                $display("FAIL %s @cycle %0d: got st=%0d bs=%b ad=%b tf=%b sc=%0d, required st=%0d bs=%b ad=%b tf=%b sc=%0d",
                         e.name, cyc_no, state, bitslip, align_done, train_fail, slip_count,
                         e.st, e.bs, e.ad, e.tf, e.sc);
            end
        end
        if (bitslip === 1'b1) begin
            if (spacing_on && last_bs >= 0) begin
                n_cmp++;
                if (cyc_no - last_bs - 1 != GAP + 1) begin
                    n_bad++;
                    $display("FAIL bitslip_spacing: got %0d idle cycles between pulses, required %0d",
                             cyc_no - last_bs - 1, GAP + 1);
                end
            end
            last_bs = cyc_no;
            bs_pulses++;
        end
    endtask

    task automatic cyc(input string n, input logic rs, input logic pl, input logic rt,
                       input logic [9:0] d, input logic [2:0] st, input logic bs,
                       input logic ad, input logic tf, input logic [3:0] sc);
        exp_t e;
        @(negedge rx_clk);
        rst = rs;
        pll_locked = pl;
        retrain = rt;
        rx_data = d;
        e.name = n; e.st = st; e.bs = bs; e.ad = ad; e.tf = tf; e.sc = sc;
        sb_q.push_back(e);
        @(posedge rx_clk);
        #1;
        check_out();
    endtask

    // Remaining WAIT cycles after the entry edge, then the edge that enters CHECK.
    task automatic wait_to_check(input string n, input int sc, input logic [9:0] d);
        for (int i = 0; i < GAP - 1; i++)
            cyc(n, 1'b0, 1'b1, 1'b0, d, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'(sc));
        cyc(n, 1'b0, 1'b1, 1'b0, d, ST_CHECK, 1'b0, 1'b0, 1'b0, 4'(sc));
    endtask

    task automatic slip_round(input string n, input int k, input logic [9:0] d);
        wait_to_check(n, k, d);
        cyc(n, 1'b0, 1'b1, 1'b0, d, ST_SLIP, 1'b1, 1'b0, 1'b0, 4'(k));
        cyc(n, 1'b0, 1'b1, 1'b0, d, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'(k + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Aligned start: lock exactly 13 edges after pll_locked is sampled high.
        add("reset",         1'b1, 1'b0, 1'b0, C1, ST_IDLE,   1'b0, 1'b0, 1'b0, 4'd0);
        add("idle_hold",     1'b0, 1'b0, 1'b0, C1, ST_IDLE,   1'b0, 1'b0, 1'b0, 4'd0);
        add("pll_rise",      1'b0, 1'b1, 1'b0, C1, ST_WAIT,   1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++)
            add("aligned_wait", 1'b0, 1'b1, 1'b0, C1, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd0);
        add("check_enter",   1'b0, 1'b1, 1'b0, C1, ST_CHECK,  1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++)
            add("aligned_check", 1'b0, 1'b1, 1'b0, C1, ST_CHECK, 1'b0, 1'b0, 1'b0, 4'd0);
        add("aligned_lock",  1'b0, 1'b1, 1'b0, C1, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd0);
        add("locked_comma2", 1'b0, 1'b1, 1'b0, C2, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd0);
        add("locked_comma2", 1'b0, 1'b1, 1'b0, C2, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd0);
        // Reset while locked, then retrain/PLL-drop collision.
        add("rst_in_locked", 1'b1, 1'b1, 1'b0, C1, ST_IDLE,   1'b0, 1'b0, 1'b0, 4'd0);
        add("restart_pll",   1'b0, 1'b1, 1'b0, C1, ST_WAIT,   1'b0, 1'b0, 1'b0, 4'd0);
        add("restart_wait",  1'b0, 1'b1, 1'b0, C1, ST_WAIT,   1'b0, 1'b0, 1'b0, 4'd0);
        add("collision",     1'b0, 1'b0, 1'b1, C1, ST_IDLE,   1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++)
            add("idle_pll_low", 1'b0, 1'b0, 1'b0, C1, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        add("pll_return",    1'b0, 1'b1, 1'b0, C1, ST_WAIT,   1'b0, 1'b0, 1'b0, 4'd0);
        add("retrain_wait",  1'b0, 1'b1, 1'b1, C1, ST_IDLE,   1'b0, 1'b0, 1'b0, 4'd0);
        add("after_retrain", 1'b0, 1'b1, 1'b0, C1, ST_WAIT,   1'b0, 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i].name, tbl[i].rs, tbl[i].pl, tbl[i].rt, tbl[i].d,
                tbl[i].st, tbl[i].bs, tbl[i].ad, tbl[i].tf, tbl[i].sc);

        // Three-slip lock: commas only appear after the third bitslip.
        cyc("ts_reset", 1'b1, 1'b0, 1'b0, NC, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("ts_pll",   1'b0, 1'b1, 1'b0, NC, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd0);
        spacing_on = 1'b1;
        last_bs = -1;
        bs_pulses = 0;
        for (int k = 0; k < 3; k++)
            slip_round("ts_slip", k, NC);
        wait_to_check("ts_wait", 3, C1);
        for (int i = 0; i < 3; i++)
            cyc("ts_check", 1'b0, 1'b1, 1'b0, C1, ST_CHECK, 1'b0, 1'b0, 1'b0, 4'd3);
        cyc("ts_lock", 1'b0, 1'b1, 1'b0, C1, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd3);
        spacing_on = 1'b0;
        n_cmp++;
        if (bs_pulses != 3) begin
            n_bad++;
            $display("FAIL ts_pulse_count: got %0d bitslip pulses, required 3", bs_pulses);
        end

        // Loss detection from the lock above.
        for (int i = 0; i < 15; i++)
            cyc("loss_short", 1'b0, 1'b1, 1'b0, NC, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd3);
        cyc("loss_recover", 1'b0, 1'b1, 1'b0, C2, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd3);
        for (int i = 0; i < 15; i++)
            cyc("loss_run", 1'b0, 1'b1, 1'b0, NC, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd3);
        cyc("loss_declared", 1'b0, 1'b1, 1'b0, NC, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd0);

        // No comma ever: ten slips, then FAIL until retrain.
        cyc("nc_reset", 1'b1, 1'b0, 1'b0, ZERO, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("nc_pll",   1'b0, 1'b1, 1'b0, ZERO, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 10; k++)
            slip_round("nc_slip", k, ZERO);
        wait_to_check("nc_wait", 10, ZERO);
        cyc("nc_fail", 1'b0, 1'b1, 1'b0, ZERO, ST_FAIL, 1'b0, 1'b0, 1'b1, 4'd10);
        for (int i = 0; i < 3; i++)
            cyc("nc_fail_hold", 1'b0, 1'b1, 1'b0, ZERO, ST_FAIL, 1'b0, 1'b0, 1'b1, 4'd10);
        cyc("nc_retrain", 1'b0, 1'b1, 1'b1, ZERO, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);

        // Interrupted CHECK: three commas, one payload word, then clean commas.
        cyc("ic_reset", 1'b1, 1'b0, 1'b0, C1, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("ic_pll",   1'b0, 1'b1, 1'b0, C1, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_to_check("ic_wait", 0, C1);
        for (int i = 0; i < 3; i++)
            cyc("ic_comma", 1'b0, 1'b1, 1'b0, C1, ST_CHECK, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("ic_payload",   1'b0, 1'b1, 1'b0, NC, ST_SLIP, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc("ic_slip_exit", 1'b0, 1'b1, 1'b0, C1, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd1);
        wait_to_check("ic_wait2", 1, C1);
        for (int i = 0; i < 3; i++)
            cyc("ic_comma2", 1'b0, 1'b1, 1'b0, C1, ST_CHECK, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc("ic_lock", 1'b0, 1'b1, 1'b0, C1, ST_LOCKED, 1'b0, 1'b1, 1'b0, 4'd1);

        // PLL drop in the middle of CHECK after one slip.
        cyc("pd_reset", 1'b1, 1'b0, 1'b0, C1, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("pd_pll",   1'b0, 1'b1, 1'b0, C1, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_to_check("pd_wait", 0, C1);
        cyc("pd_miss",      1'b0, 1'b1, 1'b0, NC, ST_SLIP, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc("pd_slip_exit", 1'b0, 1'b1, 1'b0, C1, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd1);
        wait_to_check("pd_wait2", 1, C1);
        for (int i = 0; i < 2; i++)
            cyc("pd_comma", 1'b0, 1'b1, 1'b0, C1, ST_CHECK, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc("pd_drop",  1'b0, 1'b0, 1'b0, C1, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("pd_held",  1'b0, 1'b0, 1'b0, C1, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);

        // Reset while in SLIP: no further pulse, everything back to reset values.
        cyc("rs_reset", 1'b1, 1'b0, 1'b0, NC, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("rs_pll",   1'b0, 1'b1, 1'b0, NC, ST_WAIT, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_to_check("rs_wait", 0, NC);
        cyc("rs_miss",     1'b0, 1'b1, 1'b0, NC, ST_SLIP, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc("rs_in_slip",  1'b1, 1'b1, 1'b0, NC, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc("rs_hold",     1'b1, 1'b1, 1'b0, NC, ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd0);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lvds_link_ctrl.md
LVDS_LINK_CTRL -- requirements
Module: lvds_link_ctrl

Interface
REQ-001 Parameter COMMA1, default 10'b01_0111_1100, first accepted sync word.
REQ-002 Parameter COMMA2, default 10'b10_1000_0011, second accepted sync word.
REQ-003 Parameter SLIP_GAP, default 8, settle cycles after power-up or a bitslip; range 1..255.
REQ-004 Parameter CHECK_LEN, default 4, consecutive comma words required for lock; range 1..15.
REQ-005 Parameter MAX_SLIPS, default 10, bitslip attempts before failure; range 1..15.
REQ-006 Parameter LOSS_LIMIT, default 16, consecutive non-comma words in LOCKED that declare link loss; range 2..255.
REQ-007 rx_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 rst  in  1  reset; synchronous and active-high.
REQ-009 pll_locked  in  1  LVDS receiver PLL locked and deserializer initialised.
REQ-010 rx_data  in  10  deserialized word, one per rx_clk.
REQ-011 retrain  in  1  single-cycle request to restart training.
REQ-012 bitslip  out  1  one-cycle pulse to the deserializer word-slip input.
REQ-013 align_done  out  1  high while the link is locked.
REQ-014 train_fail  out  1  high while training has failed.
REQ-015 slip_count  out  4  bitslip pulses issued in the current training attempt.
REQ-016 state  out  3  current state: IDLE=0, WAIT=1, CHECK=2, SLIP=3, LOCKED=4, FAIL=5.

Function
REQ-017 The block SHALL be a single registered FSM; all outputs decode from registers only, with no combinational input-to-output path.
REQ-018 A word is a comma iff rx_data equals COMMA1 or COMMA2.
REQ-019 IDLE: clear slip_count; on pll_locked=1 go to WAIT.
REQ-020 WAIT: count SLIP_GAP cycles from entry (entry cycle counts as 1), then go to CHECK; rx_data is ignored.
REQ-021 CHECK: hit counter cleared on entry; increment on each comma; on the CHECK_LEN-th consecutive comma go to LOCKED on the next edge.
REQ-022 CHECK miss (non-comma word): if slip_count < MAX_SLIPS go to SLIP, else go to FAIL.
REQ-023 SLIP: lasts exactly one cycle; bitslip=1 only in this state; slip_count increments by 1 on exit; next state WAIT.
REQ-024 LOCKED: align_done=1; gap counter cleared on each comma, incremented on each non-comma.
REQ-025 LOCKED: when the gap counter reaches LOSS_LIMIT, go to WAIT with slip_count cleared; align_done falls on that edge.
REQ-026 FAIL: train_fail=1; hold until retrain or pll_locked=0.
REQ-027 pll_locked=0 in any state other than IDLE forces IDLE on the next edge and clears all counters.
REQ-028 retrain=1 in any state forces IDLE on the next edge.
REQ-029 pll_locked drop SHALL take priority over retrain; both select IDLE.
REQ-030 Counters SHALL never wrap; slip_count is bounded by MAX_SLIPS.
REQ-031 Latency from pll_locked sampled high to align_done high, with clean commas and defaults: 13 edges (1 IDLE + 8 WAIT + 4 CHECK).

Reset
REQ-032 On rst=1 at an edge: state=IDLE; bitslip=0; align_done=0; train_fail=0; slip_count=0; all internal counters 0.
REQ-033 Reset asserted mid-operation, including LOCKED or SLIP, SHALL abort within that edge with no further bitslip pulse.

Verification
REQ-034 Aligned start: defaults, rx_data=COMMA1 constant, pll_locked rises -> zero bitslip pulses, align_done=1 exactly 13 edges later, slip_count=0.
REQ-035 Three-slip lock: comma appears only after the 3rd bitslip -> exactly 3 single-cycle pulses, each SLIP_GAP+1 cycles apart -> LOCKED with slip_count=3.
REQ-036 No comma ever: rx_data=10'h000 -> 10 bitslip pulses, state=5, train_fail=1, align_done=0 -> retrain pulse -> state=0, slip_count=0, train_fail=0.
REQ-037 Loss check: in LOCKED, 15 non-comma words then COMMA2 -> stays LOCKED; 16 non-comma words -> align_done=0 and state=1 on the 16th edge.
REQ-038 Interrupted CHECK: 3 commas, 1 payload word, commas -> one bitslip pulse and slip_count=1; a separate run with pll_locked=0 mid-CHECK -> state=0 next edge and slip_count=0.
REQ-039 Reset and collision: rst=1 while LOCKED -> all outputs at reset values next edge; retrain=1 and pll_locked=0 in the same cycle -> IDLE, held until pll_locked returns.
